// File: rtl/frame_scheduler.sv
// Render/display sequencer: latches a pose, starts a render, presents the frame on new_frame.
// Optional build macro SPIN_DEMO_EN makes angle_out auto-increment per render instead of tracking angle_in.
module frame_scheduler #(
    parameter int unsigned POS_W          = 16,
    parameter int unsigned ANGLE_W        = 10,
    parameter int unsigned DROP_W         = 8,
    parameter int unsigned TIMEOUT_FRAMES = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               new_frame,
    input  logic               pose_valid,
    input  logic [POS_W-1:0]   pose_x_in,
    input  logic [POS_W-1:0]   pose_y_in,
    input  logic [ANGLE_W-1:0] angle_in,
    output logic [POS_W-1:0]   pose_x_out,
    output logic [POS_W-1:0]   pose_y_out,
    output logic [ANGLE_W-1:0] angle_out,
    output logic               render_start,
    input  logic               render_done,
    output logic               render_ack,
    output logic               swap_req,
    output logic               busy,
    output logic [DROP_W-1:0]  drop_count,
    output logic               timeout
);

    typedef enum logic [1:0] {StIdle, StRender, StWaitSwap, StAck} state_e;

    localparam logic [4:0] TimeoutThr = 5'(TIMEOUT_FRAMES);

    state_e             state_q;
    logic [POS_W-1:0]   shadow_x_q;
    logic [POS_W-1:0]   shadow_y_q;
    logic [3:0]         miss_q;
    logic [3:0]         miss_next;
    logic [POS_W-1:0]   latch_x;
    logic [POS_W-1:0]   latch_y;
    logic [ANGLE_W-1:0] latch_a;

`ifdef SPIN_DEMO_EN
    logic unused_angle;
    assign unused_angle = ^angle_in;
`else
    logic [ANGLE_W-1:0] shadow_a_q;
`endif

    // Same-cycle pose_valid bypasses the shadow so the freshest pose is latched.
    always_comb begin
        latch_x   = pose_valid ? pose_x_in : shadow_x_q;
        latch_y   = pose_valid ? pose_y_in : shadow_y_q;
`ifdef SPIN_DEMO_EN
        latch_a   = (state_q == StIdle) ? '0 : angle_out + ANGLE_W'(1);
`else
        latch_a   = pose_valid ? angle_in : shadow_a_q;
`endif
        miss_next = (miss_q == 4'hF) ? miss_q : miss_q + 4'd1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= StIdle;
            shadow_x_q   <= '0;
            shadow_y_q   <= '0;
`ifndef SPIN_DEMO_EN
            shadow_a_q   <= '0;
`endif
            miss_q       <= '0;
            pose_x_out   <= '0;
            pose_y_out   <= '0;
            angle_out    <= '0;
            render_start <= 1'b0;
            render_ack   <= 1'b0;
            swap_req     <= 1'b0;
            busy         <= 1'b0;
            drop_count   <= '0;
            timeout      <= 1'b0;
        end else begin
            render_start <= 1'b0;
            render_ack   <= 1'b0;
            swap_req     <= 1'b0;
            if (pose_valid) begin
                shadow_x_q <= pose_x_in;
                shadow_y_q <= pose_y_in;
`ifndef SPIN_DEMO_EN
                shadow_a_q <= angle_in;
`endif
            end
            case (state_q)
                StIdle: begin
                    if (new_frame) begin
                        pose_x_out   <= latch_x;
                        pose_y_out   <= latch_y;
                        angle_out    <= latch_a;
                        render_start <= 1'b1;
                        busy         <= 1'b1;
                        state_q      <= StRender;
                    end
                end
                StRender: begin
                    if (render_done) begin
                        // Done coinciding with the boundary still makes the deadline.
                        if (new_frame) begin
                            swap_req   <= 1'b1;
                            render_ack <= 1'b1;
                            busy       <= 1'b0;
                            state_q    <= StAck;
                        end else begin
                            state_q <= StWaitSwap;
                        end
                    end else if (new_frame) begin
                        if (drop_count != '1) begin
                            drop_count <= drop_count + DROP_W'(1);
                        end
                        miss_q <= miss_next;
                        if ({1'b0, miss_next} >= TimeoutThr) begin
                            timeout <= 1'b1;
                        end
                    end
                end
                StWaitSwap: begin
                    if (new_frame) begin
                        swap_req   <= 1'b1;
                        render_ack <= 1'b1;
                        busy       <= 1'b0;
                        state_q    <= StAck;
                    end
                end
                StAck: begin
                    if (!render_done) begin
                        pose_x_out   <= latch_x;
                        pose_y_out   <= latch_y;
                        angle_out    <= latch_a;
                        miss_q       <= '0;
                        render_start <= 1'b1;
                        busy         <= 1'b1;
                        state_q      <= StRender;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_scheduler.sv
// Self-checking bench for frame_scheduler: randomized frames checked against a transaction-level model.
// Honours SPIN_DEMO_EN in its angle expectation.
module tb_frame_scheduler;

    localparam int POS_W          = 16;
    localparam int ANGLE_W        = 10;
    localparam int DROP_W         = 8;
    localparam int TIMEOUT_FRAMES = 4;
    localparam int DROP_MAX       = (1 << DROP_W) - 1;

    logic               Clk;
    logic               Reset;
    logic               new_frame;
    logic               pose_valid;
    logic [POS_W-1:0]   pose_x_in;
    logic [POS_W-1:0]   pose_y_in;
    logic [ANGLE_W-1:0] angle_in;
    logic [POS_W-1:0]   pose_x_out;
    logic [POS_W-1:0]   pose_y_out;
    logic [ANGLE_W-1:0] angle_out;
    logic               render_start;
    logic               render_done;
    logic               render_ack;
    logic               swap_req;
    logic               busy;
    logic [DROP_W-1:0]  drop_count;
    logic               timeout;

    frame_scheduler #(
        .POS_W          (POS_W),
        .ANGLE_W        (ANGLE_W),
        .DROP_W         (DROP_W),
        .TIMEOUT_FRAMES (TIMEOUT_FRAMES)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .new_frame    (new_frame),
        .pose_valid   (pose_valid),
        .pose_x_in    (pose_x_in),
        .pose_y_in    (pose_y_in),
        .angle_in     (angle_in),
        .pose_x_out   (pose_x_out),
        .pose_y_out   (pose_y_out),
        .angle_out    (angle_out),
        .render_start (render_start),
        .render_done  (render_done),
        .render_ack   (render_ack),
        .swap_req     (swap_req),
        .busy         (busy),
        .drop_count   (drop_count),
        .timeout      (timeout)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;

    // Reference model: shadow pose, pose of the current render, drops, misses this render.
    logic [POS_W-1:0]   m_sx, m_sy, m_x, m_y;
    logic [ANGLE_W-1:0] m_sa, m_a;
    int                 m_drop;
    int                 m_miss;
    bit                 m_to;
    bit                 m_first;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic model_reset();
        m_sx = '0; m_sy = '0; m_sa = '0;
        m_x = '0; m_y = '0; m_a = '0;
        m_drop = 0; m_miss = 0; m_to = 1'b0; m_first = 1'b1;
    endtask

    task automatic model_latch();
        m_x = m_sx;
        m_y = m_sy;
`ifdef SPIN_DEMO_EN
        m_a = m_first ? '0 : m_a + 1'b1;
`else
        m_a = m_sa;
`endif
        m_first = 1'b0;
        m_miss  = 0;
    endtask

    task automatic set_pose(input logic [POS_W-1:0] x, input logic [POS_W-1:0] y,
                            input logic [ANGLE_W-1:0] a);
        pose_valid = 1'b1;
        pose_x_in  = x;
        pose_y_in  = y;
        angle_in   = a;
        m_sx = x; m_sy = y; m_sa = a;
    endtask

    task automatic rand_pose();
        set_pose(POS_W'($urandom), POS_W'($urandom), ANGLE_W'($urandom));
    endtask

    task automatic check_pose(input string tag);
        check({tag, "_x"}, 32'(pose_x_out), 32'(m_x));
        check({tag, "_y"}, 32'(pose_y_out), 32'(m_y));
        check({tag, "_a"}, 32'(angle_out), 32'(m_a));
    endtask

    task automatic check_start();
        check("render_start", 32'(render_start), 32'd1);
        check("busy_on_start", 32'(busy), 32'd1);
        check_pose("pose_latched");
    endtask

    // One cycle of background activity: pose updates must only reach the shadow.
    task automatic idle_step();
        if ($urandom_range(3) == 0) rand_pose();
        step();
        pose_valid = 1'b0;
        check_pose("pose_stable");
    endtask

    task automatic do_frame(input int misses, input int done_gap, input bit coincide,
                            input int ack_hold, input bit nf_in_ack, input bit pv_at_latch);
        for (int i = 0; i < misses; i++) begin
            repeat ($urandom_range(3) + 1) idle_step();
            new_frame = 1'b1;
            step();
            new_frame = 1'b0;
            if (m_drop < DROP_MAX) m_drop++;
            m_miss++;
            if (m_miss >= TIMEOUT_FRAMES) m_to = 1'b1;
            check("drop_on_miss", 32'(drop_count), 32'(m_drop));
            check("timeout_on_miss", 32'(timeout), 32'(m_to));
            check("busy_in_render", 32'(busy), 32'd1);
        end
        render_done = 1'b1;
        if (!coincide) begin
            step();
            check("busy_wait_swap", 32'(busy), 32'd1);
            for (int i = 0; i < done_gap; i++) begin
                idle_step();
                check("swap_held", 32'(swap_req), 32'd0);
            end
        end
        new_frame = 1'b1;
        step();
        new_frame = 1'b0;
        check("swap_req", 32'(swap_req), 32'd1);
        check("render_ack", 32'(render_ack), 32'd1);
        check("drop_at_swap", 32'(drop_count), 32'(m_drop));
        check("timeout_at_swap", 32'(timeout), 32'(m_to));
        for (int i = 0; i < ack_hold; i++) begin
            if (nf_in_ack && i == 0) new_frame = 1'b1;
            step();
            new_frame = 1'b0;
            check("busy_in_ack", 32'(busy), 32'd0);
            check("no_restart_in_ack", 32'(render_start), 32'd0);
            check("drop_in_ack", 32'(drop_count), 32'(m_drop));
        end
        render_done = 1'b0;
        if (pv_at_latch) rand_pose();
        step();
        pose_valid = 1'b0;
        model_latch();
        check_start();
    endtask

    // Strobe outputs: never two cycles in a row; swap and ack always together.
    logic prev_rs, prev_sw, prev_ack;
    always @(posedge Clk) begin
        #1;
        if (!Reset) begin
            if (render_start) check("render_start_b2b", 32'(prev_rs), 32'd0);
            if (swap_req) check("swap_req_b2b", 32'(prev_sw), 32'd0);
            if (render_ack) check("render_ack_b2b", 32'(prev_ack), 32'd0);
            if (swap_req || render_ack) check("swap_ack_pair", 32'(swap_req), 32'(render_ack));
        end
        prev_rs  = render_start;
        prev_sw  = swap_req;
        prev_ack = render_ack;
    end

    initial begin
        Reset = 1'b1; new_frame = 1'b0; pose_valid = 1'b0; render_done = 1'b0;
        pose_x_in = '0; pose_y_in = '0; angle_in = '0;
        model_reset();
        step();
        step();
        check("rst_start", 32'(render_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check_pose("rst_pose");
        Reset = 1'b0;
        repeat (3) idle_step();
        check("idle_busy", 32'(busy), 32'd0);

        // First render with a directed pose.
        set_pose(16'd128, 16'd128, 10'd5);
        step();
        pose_valid = 1'b0;
        new_frame = 1'b1;
        step();
        new_frame = 1'b0;
        model_latch();
        check_start();

        // Slow but on-time render: done after 100 cycles, boundary 500 later.
        repeat (99) step();
        do_frame(0, 500, 1'b0, 2, 1'b0, 1'b0);
        check("drop_zero", 32'(drop_count), 32'd0);

        // Mid-render pose change must wait for the next render_start.
        set_pose(16'd300, 16'd400, 10'd9);
        step();
        pose_valid = 1'b0;
        check_pose("pose_hold_mid");

        // Four misses: timeout on the fourth, sticky afterwards.
        do_frame(4, 3, 1'b0, 1, 1'b1, 1'b0);
        do_frame(0, 2, 1'b1, 0, 1'b0, 1'b0);
        check("timeout_sticky", 32'(timeout), 32'd1);

        for (int f = 0; f < 25; f++) begin
            do_frame($urandom_range(3), $urandom_range(6), 1'($urandom_range(1)),
                     $urandom_range(3), 1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        // Enough misses to saturate the drop counter.
        do_frame(DROP_MAX + 5, 1, 1'b0, 1, 1'b0, 1'b0);
        check("drop_saturated", 32'(drop_count), 32'(DROP_MAX));

        // Asynchronous reset mid-render.
        repeat (3) idle_step();
        #2;
        Reset = 1'b1;
        #1;
        model_reset();
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_drop", 32'(drop_count), 32'd0);
        check("arst_timeout", 32'(timeout), 32'd0);
        check("arst_start", 32'(render_start), 32'd0);
        check_pose("arst_pose");
        step();
        Reset = 1'b0;
        step();
        check("post_rst_busy", 32'(busy), 32'd0);
        new_frame = 1'b1;
        step();
        new_frame = 1'b0;
        model_latch();
        check_start();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/frame_scheduler.md
Name: frame_scheduler

Overview:
Sequences the render pipeline against the display timing.
- Latches a stable player pose and issues a render start.
- Holds the finished frame until the next new_frame boundary, then pulses the framebuffer swap and the render acknowledge together.
- Counts frames that missed their deadline.
- Sits between game/pose logic, render_module, framebuffer_module and output_module's new_frame pulse.

Parameters:
POS_W, 16, width of each pose coordinate (x, y)
ANGLE_W, 10, width of player angle
DROP_W, 8, width of saturating dropped-frame counter
TIMEOUT_FRAMES, 4, new_frame pulses tolerated in RENDER before timeout flag sets (1..15)

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
new_frame  in  1  one-cycle pulse at start of vertical blank
pose_valid  in  1  qualifies pose_x_in/pose_y_in/angle_in this cycle
pose_x_in  in  POS_W  requested player x
pose_y_in  in  POS_W  requested player y
angle_in  in  ANGLE_W  requested player angle
pose_x_out  out  POS_W  latched x, stable for a whole render
pose_y_out  out  POS_W  latched y
angle_out  out  ANGLE_W  latched angle
render_start  out  1  one-cycle pulse: begin rendering with latched pose
render_done  in  1  level from render module, high until acked
render_ack  out  1  one-cycle pulse acknowledging render_done
swap_req  out  1  one-cycle pulse to framebuffer: present completed buffer
busy  out  1  high in RENDER or WAIT_SWAP
drop_count  out  DROP_W  saturating count of missed frame deadlines
timeout  out  1  sticky: render exceeded TIMEOUT_FRAMES

Behaviour:
- Reset (async, active-high) forces:
  - state IDLE
  - all outputs 0
  - pose shadow and latched pose 0
  - frame-miss counter 0
- Pose shadow register loads the *_in values on every cycle with pose_valid=1; otherwise it holds.
- All outputs are registered.
- IDLE: the first new_frame after reset latches the shadow into *_out and pulses render_start the next cycle; goes to RENDER.
- RENDER: waits for render_done=1.
  - new_frame with render_done=0: drop_count += 1 (saturates at all-ones); miss counter += 1.
  - Miss counter reaching TIMEOUT_FRAMES sets timeout (stays set until Reset). The FSM keeps waiting; it never aborts.
  - render_done=1 with no new_frame: go to WAIT_SWAP.
  - render_done=1 and new_frame in the same cycle: treated as on time, no drop. swap_req and render_ack pulse the next cycle; go to ACK.
- WAIT_SWAP: on new_frame, swap_req and render_ack pulse together on the next cycle; go to ACK.
- ACK: waits for render_done=0. In that cycle it:
  - latches the shadow into *_out
  - clears the miss counter
  - pulses render_start the next cycle
  - returns to RENDER (back-to-back rendering, no IDLE).
  - new_frame arriving while in ACK is not counted as a drop.
- Pose outputs change only on the cycle render_start is asserted. pose_valid during RENDER affects only the shadow.
- render_start, render_ack and swap_req are never high for two consecutive cycles.
- Reset mid-render returns to IDLE. render_module must be reset by the same Reset.
- pose_valid in the same cycle as the latch: the new input value is latched (shadow bypass).

Optional Feature:
SPIN_DEMO_EN
- Defined:
  - angle_in and pose_valid are ignored for angle; the x/y path is unchanged.
  - angle_out increments by 1 (mod 2^ANGLE_W) at every render_start after the first. The first render uses angle 0.
- Undefined: angle_out comes from the shadow like x/y.

Test Plan:
1. Reset, pose_valid with x=128, y=128, angle=5, then new_frame -> render_start pulses 1 cycle later; pose_out=(128,128,5); busy=1.
2. render_done rises 100 cycles after start; new_frame 500 cycles later -> swap_req and render_ack pulse together 1 cycle after new_frame. render_done drops -> render_start 1 cycle later; drop_count=0.
3. Hold render_done low across 3 new_frame pulses -> drop_count=3, timeout=0. A 4th pulse -> drop_count=4, timeout=1. Then render_done -> normal swap on the next new_frame; timeout stays 1.
4. render_done and new_frame in the same cycle -> swap_req next cycle, drop_count unchanged.
5. pose_valid changes to angle=9 mid-render -> angle_out stays 5 until the next render_start, then 9.
6. With SPIN_DEMO_EN defined, run 3 frames -> angle_out = 0, 1, 2 regardless of angle_in. Assert Reset mid-RENDER -> all outputs 0 immediately (async), state IDLE.
